mul_seq_ctrl: RTL



---
 rtl/mul_pkg.sv | 16 +
 rtl/modifiedAdder_32bit.sv | 23 ++
 rtl/mul_seq_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mul_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
`timescale 1ns/1ps
package mul_pkg;

  // Controller states: waiting for operands, iterating, holding the product.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_state_t;

  localparam int MUL_OPERAND_W = 16;
  localparam int MUL_PRODUCT_W = 32;
  localparam int MUL_ITER      = 16;

endpackage

// File: rtl/modifiedAdder_32bit.sv
// 32-bit ripple-carry adder; the single adder time-shared by mul_seq_ctrl.
`timescale 1ns/1ps
module modifiedAdder_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum,
  output logic        cout
);

  logic [32:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, carry rippling from bit 0 upward.
  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[32];

endmodule

// File: rtl/mul_seq_ctrl.sv
// Sequential 16x16 unsigned shift-and-add multiplier with valid/ready on both
// sides. One 32-bit adder is reused for all 16 iterations.
// Optional macro MUL_SEQ_SKIP_ZERO_EN: finish early once the remaining
// multiplier bits are all zero (product is unchanged either way).
`timescale 1ns/1ps
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int OPERAND_W = MUL_OPERAND_W,
  parameter int CNT_W     = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [OPERAND_W-1:0]     a,
  input  logic [OPERAND_W-1:0]     b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*OPERAND_W-1:0]   y,
  output logic                     busy
);

  // The product must exactly fill the shared 32-bit adder, and the counter
  // must be able to reach the last iteration index.
  if (2 * OPERAND_W != MUL_PRODUCT_W) begin : g_bad_operand_w
    $error("mul_seq_ctrl: OPERAND_W must be 16 so the product matches the 32-bit adder");
  end
  if ((1 << CNT_W) <= OPERAND_W) begin : g_bad_cnt_w
    $error("mul_seq_ctrl: CNT_W too small to count all iterations");
  end

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITER - 1);

  mul_state_t               state_q, state_d;
  logic [MUL_PRODUCT_W-1:0] a_sh_q, a_sh_d;
  logic [OPERAND_W-1:0]     b_sh_q, b_sh_d;
  logic [MUL_PRODUCT_W-1:0] acc_q, acc_d;
  logic [MUL_PRODUCT_W-1:0] y_q, y_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic [MUL_PRODUCT_W-1:0] add_sum;
  logic                     cout_unused;
  logic                     skip_zero;

  modifiedAdder_32bit u_adder (
    .a    (acc_q),
    .b    (a_sh_q),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (cout_unused)
  );

`ifdef MUL_SEQ_SKIP_ZERO_EN
  assign skip_zero = (b_sh_q == '0);
`else
  assign skip_zero = 1'b0;
`endif

  // State, operand shifters, accumulator, counter and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      y_q     <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: load on accept, one add/shift step per RUN cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    y_d     = y_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = MUL_PRODUCT_W'(a);
          b_sh_d  = b;
          acc_d   = '0;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (skip_zero) begin
          state_d = DONE;
        end else begin
          if (b_sh_q[0]) begin
            acc_d = add_sum;
          end
          a_sh_d  = a_sh_q << 1;
          b_sh_d  = b_sh_q >> 1;
          count_d = count_q + CNT_W'(1);
          if (count_q == LAST_ITER) begin
            state_d = DONE;
          end
        end
        y_d = acc_d;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign y         = y_q;

endmodule
